// File: rtl/qed_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qed_pkg : opcodes, instruction classes and FSM states for qed_dup_engine
// Rev 1.0
// ----------------------------------------------------------------------------
package qed_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE
  } cls_e;

  typedef enum logic [0:0] {
    ST_ORIG,
    ST_DUP
  } state_e;

  function automatic cls_e classify(input logic [6:0] op);
    case (op)
      OP_R:     return CLS_R;
      OP_I:     return CLS_I;
      OP_LOAD:  return CLS_LOAD;
      OP_STORE: return CLS_STORE;
      default:  return CLS_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/qed_remap.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qed_remap : classifies an instruction and builds its EDDI-V duplicate
// Rev 1.0
// ----------------------------------------------------------------------------
module qed_remap
  import qed_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int IMM_KEEP = 10
) (
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_dup,
  output cls_e            o_cls
);

  // Duplicate memory offsets keep the low IMM_KEEP bits and force the upper field to 01.
  localparam logic [11:0] c_KEEP_MASK = 12'((1 << IMM_KEEP) - 1);
  localparam logic [11:0] c_DUP_BASE  = 12'(1 << IMM_KEEP);

  function automatic logic [REG_W-1:0] dup_reg(input logic [REG_W-1:0] r);
    return (r == '0) ? r : {1'b1, r[REG_W-2:0]};
  endfunction

  logic [11:0] w_ld_imm;
  logic [11:0] w_st_imm;

  always_comb begin
    o_cls    = classify(i_instr[6:0]);
    w_ld_imm = (i_instr[31:20] & c_KEEP_MASK) | c_DUP_BASE;
    w_st_imm = ({i_instr[31:25], i_instr[11:7]} & c_KEEP_MASK) | c_DUP_BASE;
    o_dup    = i_instr;
    case (o_cls)
      CLS_R: begin
        o_dup[7 +: REG_W]  = dup_reg(i_instr[7 +: REG_W]);
        o_dup[15 +: REG_W] = dup_reg(i_instr[15 +: REG_W]);
        o_dup[20 +: REG_W] = dup_reg(i_instr[20 +: REG_W]);
      end
      CLS_I: begin
        o_dup[7 +: REG_W]  = dup_reg(i_instr[7 +: REG_W]);
        o_dup[15 +: REG_W] = dup_reg(i_instr[15 +: REG_W]);
      end
      CLS_LOAD: begin
        o_dup[7 +: REG_W]  = dup_reg(i_instr[7 +: REG_W]);
        o_dup[15 +: REG_W] = dup_reg(i_instr[15 +: REG_W]);
        o_dup[31:20]       = w_ld_imm;
      end
      CLS_STORE: begin
        o_dup[15 +: REG_W] = dup_reg(i_instr[15 +: REG_W]);
        o_dup[20 +: REG_W] = dup_reg(i_instr[20 +: REG_W]);
        o_dup[31:25]       = w_st_imm[11:5];
        o_dup[11:7]        = w_st_imm[4:0];
      end
      default: o_dup = i_instr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/qed_dup_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qed_dup_engine : EDDI-V duplication engine between fetch and decode
// Rev 1.0
// ----------------------------------------------------------------------------
module qed_dup_engine
  import qed_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int DEPTH    = 4,
  parameter int IMM_KEEP = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     exec_dup,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_is_dup,
  output logic [$clog2(DEPTH):0]   qcount,
  output logic                     qed_ready
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;

  state_e            r_state;
  state_e            w_state_next;
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [XLEN-1:0]   r_mem [DEPTH];
  logic              r_out_valid;
  logic              r_out_is_dup;
  logic [XLEN-1:0]   r_out_instr;
  logic              r_qed_ready;

  logic [c_PW-1:0]   w_count;
  logic [c_PW-1:0]   w_count_next;
  logic              w_full;
  logic              w_empty;
  logic              w_out_load;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_valid_next;
  logic              w_is_dup_next;
  logic [XLEN-1:0]   w_remap_in;
  logic [XLEN-1:0]   w_dup;
  cls_e              w_cls;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_out_load = !r_out_valid || out_ready;

  // One remapper serves both modes: classify fetch in ORIG, remap the queue head in DUP.
  assign w_remap_in = (r_state == ST_DUP) ? r_mem[r_rd_ptr[c_AW-1:0]] : in_instr;

  qed_remap #(
    .XLEN     (XLEN),
    .REG_W    (REG_W),
    .IMM_KEEP (IMM_KEEP)
  ) u_remap (
    .i_instr (w_remap_in),
    .o_dup   (w_dup),
    .o_cls   (w_cls)
  );

  always_comb begin
    in_ready      = 1'b0;
    w_accept      = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_state_next  = r_state;
    w_count_next  = w_count;
    w_valid_next  = r_out_valid && !out_ready;
    w_is_dup_next = r_out_is_dup;
    case (r_state)
      ST_ORIG: begin
        in_ready = w_out_load && !w_full;
        w_accept = in_valid && in_ready;
        w_push   = w_accept && ena && (w_cls != CLS_NONE);
        if (w_accept) begin
          w_valid_next  = 1'b1;
          w_is_dup_next = 1'b0;
        end
        w_count_next = w_count + c_PW'(w_push);
        if ((w_count_next != '0) && (exec_dup || (w_count_next == c_PW'(DEPTH))))
          w_state_next = ST_DUP;
      end
      ST_DUP: begin
        w_pop = w_out_load && !w_empty;
        if (w_pop) begin
          w_valid_next  = 1'b1;
          w_is_dup_next = 1'b1;
        end
        w_count_next = w_count - c_PW'(w_pop);
        if (w_count_next == '0)
          w_state_next = ST_ORIG;
      end
      default: w_state_next = ST_ORIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ORIG;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_out_valid  <= 1'b0;
      r_out_is_dup <= 1'b0;
      r_out_instr  <= '0;
      r_qed_ready  <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_out_valid  <= w_valid_next;
      r_out_is_dup <= w_is_dup_next;
      r_qed_ready  <= (w_state_next == ST_ORIG) && (w_count_next == '0) &&
                      !(w_valid_next && w_is_dup_next);
      if (w_accept)
        r_out_instr <= in_instr;
      else if (w_pop)
        r_out_instr <= w_dup;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
    end
  end

  // Queue keeps the original encoding; remap happens on the way out.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[c_AW-1:0]] <= in_instr;
  end

  assign out_valid  = r_out_valid;
  assign out_instr  = r_out_instr;
  assign out_is_dup = r_out_is_dup;
  assign qcount     = w_count;
  assign qed_ready  = r_qed_ready;

endmodule
`default_nettype wire

// File: tb/tb_qed_dup_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_qed_dup_engine : directed + randomized bench with a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_qed_dup_engine;

  localparam int DEPTH    = 4;
  localparam int IMM_KEEP = 10;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          exec_dup = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   in_instr = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_is_dup;
  logic          qed_ready;
  logic [31:0]   out_instr;
  logic [CW-1:0] qcount;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  logic [31:0] mq[$];
  bit          m_dup;
  bit          m_valid;
  bit          m_isdup;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  qed_dup_engine #(
    .XLEN(32), .REG_W(5), .DEPTH(DEPTH), .IMM_KEEP(IMM_KEEP)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .exec_dup(exec_dup),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_is_dup(out_is_dup), .qcount(qcount), .qed_ready(qed_ready)
  );

  function automatic bit m_supported(input logic [31:0] x);
    int op = int'(x[6:0]);
    return (op == 'h33) || (op == 'h13) || (op == 'h03) || (op == 'h23);
  endfunction

  function automatic int m_reg(input int r);
    return (r == 0) ? 0 : 16 + (r % 16);
  endfunction

  function automatic logic [31:0] m_remap(input logic [31:0] x);
    logic [31:0] y = x;
    int op = int'(x[6:0]);
    int imm;
    if (!m_supported(x)) return x;
    if (op != 'h23) y[11:7] = 5'(m_reg(int'(x[11:7])));
    y[19:15] = 5'(m_reg(int'(x[19:15])));
    if (op == 'h33 || op == 'h23) y[24:20] = 5'(m_reg(int'(x[24:20])));
    if (op == 'h03) begin
      imm = int'(x[31:20]);
      imm = (imm % (1 << IMM_KEEP)) + (1 << IMM_KEEP);
      y[31:20] = imm[11:0];
    end
    if (op == 'h23) begin
      imm = int'({x[31:25], x[11:7]});
      imm = (imm % (1 << IMM_KEEP)) + (1 << IMM_KEEP);
      y[31:25] = imm[11:5];
      y[11:7]  = imm[4:0];
    end
    return y;
  endfunction

  // Reference model: one transfer per cycle, queue of originals, mode flag.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_dup   <= 1'b0;
      m_valid <= 1'b0;
      m_isdup <= 1'b0;
      m_instr <= '0;
    end else if (!m_dup) begin
      if (in_valid && (!m_valid || out_ready) && mq.size() < DEPTH) begin
        m_valid <= 1'b1;
        m_instr <= in_instr;
        m_isdup <= 1'b0;
        if (ena && m_supported(in_instr)) mq.push_back(in_instr);
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (mq.size() != 0 && (exec_dup || mq.size() == DEPTH)) m_dup <= 1'b1;
    end else begin
      if ((!m_valid || out_ready) && mq.size() != 0) begin
        m_instr <= m_remap(mq.pop_front());
        m_isdup <= 1'b1;
        m_valid <= 1'b1;
        if (mq.size() == 0) m_dup <= 1'b0;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("sb_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("sb_out_instr", out_instr, m_instr);
        check("sb_out_is_dup", 32'(out_is_dup), 32'(m_isdup));
      end
      check("sb_qcount", 32'(qcount), 32'(mq.size()));
      check("sb_qed_ready", 32'(qed_ready),
            32'(!m_dup && mq.size() == 0 && !(m_valid && m_isdup)));
      check("sb_in_ready", 32'(in_ready),
            32'(!m_dup && (!m_valid || out_ready) && mq.size() < DEPTH));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dup(input string name, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      next_cycle();
      if (out_valid && out_is_dup) seen = 1'b1;
    end
    if (seen) check(name, out_instr, exp);
    else begin
      checks++;
      errors++;
      $display("FAIL %s: no duplicate issued within 10 cycles, expected %h", name, exp);
    end
  endtask

  task automatic push(input logic [31:0] x, input logic ex);
    in_valid = 1'b1; in_instr = x; exec_dup = ex;
    next_cycle();
    in_valid = 1'b0; exec_dup = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] x = $urandom;
    case ($urandom_range(0, 5))
      0: x[6:0] = 7'h33;
      1: x[6:0] = 7'h13;
      2: x[6:0] = 7'h03;
      3: x[6:0] = 7'h23;
      4: x[6:0] = 7'h6F;
      default: x[6:0] = 7'h37;
    endcase
    return x;
  endfunction

  initial begin
    next_cycle();
    next_cycle();
    armed = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_is_dup", 32'(out_is_dup), 32'd0);
    check("rst_qcount", 32'(qcount), 32'd0);
    check("rst_qed_ready", 32'(qed_ready), 32'd1);
    rst = 1'b0; ena = 1'b1; out_ready = 1'b1;

    // add x1,x2,x3 then exec_dup
    push(32'h003100B3, 1'b0);
    check("add_orig", out_instr, 32'h003100B3);
    check("add_orig_flag", 32'(out_is_dup), 32'd0);
    check("add_qed_low", 32'(qed_ready), 32'd0);
    exec_dup = 1'b1;
    next_cycle();
    exec_dup = 1'b0;
    wait_dup("add_dup", 32'h013908B3);
    check("add_qed_during_dup", 32'(qed_ready), 32'd0);
    next_cycle();
    check("add_qed_back", 32'(qed_ready), 32'd1);

    // lw x1,8(x2)
    push(32'h00812083, 1'b0);
    exec_dup = 1'b1;
    next_cycle();
    exec_dup = 1'b0;
    wait_dup("lw_dup", 32'h40892883);

    // addi x0,x0,0 with exec_dup in the same cycle
    push(32'h00000013, 1'b1);
    wait_dup("nop_dup", 32'h00000013);

    // jal is passed through and never queued; exec_dup on an empty queue stays in ORIG
    push(32'h0000006F, 1'b0);
    check("jal_pass", out_instr, 32'h0000006F);
    check("jal_qcount", 32'(qcount), 32'd0);
    exec_dup = 1'b1;
    next_cycle();
    exec_dup = 1'b0;
    check("jal_in_ready", 32'(in_ready), 32'd1);

    // ena low: pass-through only
    ena = 1'b0;
    push(32'h003100B3, 1'b1);
    check("ena0_qcount", 32'(qcount), 32'd0);
    check("ena0_flag", 32'(out_is_dup), 32'd0);
    ena = 1'b1;
    next_cycle();

    // fill to DEPTH, forced drain with a mid-drain stall
    push(32'h003100B3, 1'b0);
    push(32'h00812083, 1'b0);
    push(32'h00000013, 1'b0);
    push(32'h00312223, 1'b0);
    check("full_qcount", 32'(qcount), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    wait_dup("drain_0", 32'h013908B3);
    check("drain_qcount3", 32'(qcount), 32'd3);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      check("stall_instr", out_instr, 32'h013908B3);
      check("stall_qcount", 32'(qcount), 32'd3);
    end
    out_ready = 1'b1;
    wait_dup("drain_1", 32'h40892883);
    wait_dup("drain_2", 32'h00000013);
    wait_dup("drain_3", 32'h41392223);
    check("drain_qcount0", 32'(qcount), 32'd0);
    next_cycle();
    check("drain_qed", 32'(qed_ready), 32'd1);

    // reset in DUP with two entries left
    push(32'h003100B3, 1'b0);
    push(32'h00812083, 1'b0);
    push(32'h00312223, 1'b0);
    exec_dup = 1'b1;
    next_cycle();
    exec_dup = 1'b0;
    next_cycle();
    check("pre_rst_qcount", 32'(qcount), 32'd2);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_qcount", 32'(qcount), 32'd0);
    check("mid_rst_qed", 32'(qed_ready), 32'd1);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      ena       = ($urandom_range(0, 9) != 0);
      exec_dup  = ($urandom_range(0, 5) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_instr  = gen_instr();
      out_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    rst = 1'b0; in_valid = 1'b0; exec_dup = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) next_cycle();
    exec_dup = 1'b0;
    check("final_qcount", 32'(qcount), 32'd0);
    check("final_qed", 32'(qed_ready), 32'd1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
